// File: rtl/shifter_pkg.sv
// Shared opcodes, requester-ID width and output-slot state encoding for the
// shared shift/rotate arbiter.
package shifter_pkg;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  localparam int ID_W = 1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/shift_core.sv
// Combinational log2(WIDTH)-stage barrel shifter/rotator.
// Stage i moves the operand by 2**i when amount bit i is set.
module shift_core
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] s,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] stg [AMT_W+1];

  assign stg[0] = a;

  for (genvar i = 0; i < AMT_W; i++) begin : g_stage
    localparam int SH = 1 << i;
    logic [WIDTH-1:0] moved;

    // Sign fill for SRA uses the current stage MSB, which earlier stages keep equal to a[WIDTH-1].
    always_comb begin
      case (op)
        OP_ROL:  moved = {stg[i][WIDTH-SH-1:0], stg[i][WIDTH-1:WIDTH-SH]};
        OP_ROR:  moved = {stg[i][SH-1:0], stg[i][WIDTH-1:SH]};
        OP_SLL:  moved = {stg[i][WIDTH-SH-1:0], {SH{1'b0}}};
        OP_SRL:  moved = {{SH{1'b0}}, stg[i][WIDTH-1:SH]};
        OP_SRA:  moved = {{SH{stg[i][WIDTH-1]}}, stg[i][WIDTH-1:SH]};
        default: moved = stg[i];
      endcase
    end

    assign stg[i+1] = s[i] ? moved : stg[i];
  end

  assign y = stg[AMT_W];

endmodule

// File: rtl/shifter_arbiter_16.sv
// Two-requester round-robin front end sharing one shift_core, with a
// one-deep registered result slot tagged by requester ID.
module shifter_arbiter_16
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [2:0]       req1_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [ID_W-1:0]  out_id
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]  out_id_q, out_id_d;
  logic [ID_W-1:0]  rr_q, rr_d;

  logic             free;
  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_id;
  logic [WIDTH-1:0] sel_data;
  logic [AMT_W-1:0] sel_amt;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] core_y;

  assign free = (state_q == SLOT_EMPTY) || out_ready;

  // A lone requester wins outright; contention is broken by the rr pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (free) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = rr_q;
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_vld && (gnt_id == 1'b0);
  assign req1_ready = gnt_vld && (gnt_id == 1'b1);

  assign sel_data = (gnt_id == 1'b1) ? req1_data : req0_data;
  assign sel_amt  = (gnt_id == 1'b1) ? req1_amt  : req0_amt;
  assign sel_op   = (gnt_id == 1'b1) ? req1_op   : req0_op;

  shift_core #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_core (
    .a  (sel_data),
    .s  (sel_amt),
    .op (sel_op),
    .y  (core_y)
  );

  // Slot FSM: an accept always (re)loads, a drain without accept empties.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    rr_d       = rr_q;
    if (gnt_vld) begin
      state_d    = SLOT_FULL;
      out_data_d = core_y;
      out_id_d   = gnt_id;
      rr_d       = ~gnt_id;
    end else begin
      case (state_q)
        SLOT_FULL:  if (out_ready) state_d = SLOT_EMPTY;
        default:    state_d = SLOT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SLOT_EMPTY;
      out_data_q <= '0;
      out_id_q   <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      rr_q       <= rr_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_shifter_arbiter_16.sv
// Bench for shifter_arbiter_16: directed steps followed by random traffic,
// checked against an arithmetic model of the shift ops and arbitration rules.
module tb_shifter_arbiter_16;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0]  req0_data, req1_data;
  logic [AW-1:0] req0_amt, req1_amt;
  logic [2:0]    req0_op, req1_op;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic [0:0]    out_id;

  int checks = 0;
  int errors = 0;

  logic          rr_m;
  logic          exp_valid;
  logic [W-1:0]  exp_data;
  logic          exp_id;

  shifter_arbiter_16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_op    (req1_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_core(input logic [W-1:0] a, input int s, input logic [2:0] op);
    logic [2*W-1:0]        dbl;
    logic signed [2*W-1:0] ext;
    logic [2*W-1:0]        tmp;
    dbl = {a, a};
    ext = {{W{a[W-1]}}, a};
    case (op)
      3'd0: begin tmp = dbl << s; return tmp[2*W-1:W]; end
      3'd1: begin tmp = dbl >> s; return tmp[W-1:0]; end
      3'd2: begin tmp = {{W{1'b0}}, a} << s; return tmp[W-1:0]; end
      3'd3: begin tmp = {{W{1'b0}}, a} >> s; return tmp[W-1:0]; end
      3'd4: begin tmp = ext >>> s; return tmp[W-1:0]; end
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rr_m      = 1'b0;
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_id    = 1'b0;
  endtask

  task automatic drive(input logic v0, input logic [W-1:0] d0, input logic [AW-1:0] a0, input logic [2:0] o0,
                       input logic v1, input logic [W-1:0] d1, input logic [AW-1:0] a1, input logic [2:0] o1,
                       input logic ordy);
    req0_valid = v0; req0_data = d0; req0_amt = a0; req0_op = o0;
    req1_valid = v1; req1_data = d1; req1_amt = a1; req1_op = o1;
    out_ready  = ordy;
  endtask

  // One clock: check readies against the model, advance the model at the edge, check the slot.
  task automatic cyc(input string tag);
    logic free, gv, gid;
    #1;
    free = !exp_valid || out_ready;
    gv = 1'b0; gid = 1'b0;
    if (free) begin
      if (req0_valid && req1_valid) begin gv = 1'b1; gid = rr_m; end
      else if (req0_valid) gv = 1'b1;
      else if (req1_valid) begin gv = 1'b1; gid = 1'b1; end
    end
    chk({tag, ".rdy0"}, W'(req0_ready), W'(gv && !gid));
    chk({tag, ".rdy1"}, W'(req1_ready), W'(gv && gid));
    @(posedge clk);
    if (gv) begin
      exp_data  = gid ? ref_core(req1_data, int'(req1_amt), req1_op)
                      : ref_core(req0_data, int'(req0_amt), req0_op);
      exp_id    = gid;
      exp_valid = 1'b1;
      rr_m      = ~gid;
    end else if (out_ready) begin
      exp_valid = 1'b0;
    end
    #1;
    chk({tag, ".valid"}, W'(out_valid), W'(exp_valid));
    chk({tag, ".data"},  out_data, exp_data);
    chk({tag, ".id"},    W'(out_id), W'(exp_id));
  endtask

  initial begin
    model_reset();
    drive(1'b0, '0, '0, 3'd0, 1'b0, '0, '0, 3'd0, 1'b1);
    #12;
    chk("rst.valid", W'(out_valid), '0);
    chk("rst.data",  out_data, '0);
    chk("rst.id",    W'(out_id), '0);
    rst_n = 1'b1;

    // Single-requester operations with literal results.
    drive(1'b1, 16'h8001, 4'd1, 3'd0, 1'b0, '0, '0, 3'd0, 1'b1);
    cyc("rol1");
    chk("rol1.lit", out_data, 16'h0003);
    drive(1'b0, '0, '0, 3'd0, 1'b1, 16'h0001, 4'd4, 3'd1, 1'b1);
    cyc("ror4");
    chk("ror4.lit", out_data, 16'h1000);
    chk("ror4.idlit", W'(out_id), 16'd1);
    drive(1'b0, '0, '0, 3'd0, 1'b1, 16'h8000, 4'd3, 3'd4, 1'b1);
    cyc("sra3");
    chk("sra3.lit", out_data, 16'hF000);
    drive(1'b0, '0, '0, 3'd0, 1'b1, 16'h8000, 4'd3, 3'd3, 1'b1);
    cyc("srl3");
    chk("srl3.lit", out_data, 16'h1000);
    drive(1'b0, '0, '0, 3'd0, 1'b0, '0, '0, 3'd0, 1'b1);
    cyc("drain");

    // Fresh reset, then continuous contention alternates 0,1,0,1.
    rst_n = 1'b0; #1; model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'h0F0F, 4'(k), 3'd0, 1'b1, 16'hF0F0, 4'(k), 3'd1, 1'b1);
      cyc("alt");
      chk("alt.idlit", W'(out_id), W'(k % 2));
    end

    // Backpressure: SLL result must hold while out_ready is low.
    drive(1'b1, 16'h00FF, 4'd8, 3'd2, 1'b0, '0, '0, 3'd0, 1'b1);
    cyc("sll8");
    chk("sll8.lit", out_data, 16'hFF00);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'h1234, 4'd2, 3'd0, 1'b1, 16'h4321, 4'd3, 3'd1, 1'b0);
      cyc("hold");
      chk("hold.lit", out_data, 16'hFF00);
    end
    out_ready = 1'b1;
    #1;
    chk("release.rdy1", W'(req1_ready), 16'd1);
    cyc("release");

    // Zero amount is identity for every opcode; pass-through opcodes ignore the amount.
    for (int op = 0; op < 5; op++) begin
      drive(1'b1, 16'hA5C3, 4'd0, 3'(op), 1'b0, '0, '0, 3'd0, 1'b1);
      cyc("amt0");
      chk("amt0.lit", out_data, 16'hA5C3);
    end
    drive(1'b0, '0, '0, 3'd0, 1'b1, 16'hA5C3, 4'd7, 3'd7, 1'b1);
    cyc("pass7");
    chk("pass7.lit", out_data, 16'hA5C3);
    drive(1'b1, 16'hFFFE, 4'd15, 3'd0, 1'b0, '0, '0, 3'd0, 1'b1);
    cyc("rol15");
    chk("rol15.lit", out_data, 16'h7FFF);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 7));
      cyc("rand");
    end

    // Asynchronous reset while holding a result under backpressure.
    drive(1'b1, 16'h00F0, 4'd1, 3'd2, 1'b0, '0, '0, 3'd0, 1'b1);
    cyc("prefill");
    drive(1'b1, 16'h1111, 4'd1, 3'd0, 1'b1, 16'h2222, 4'd1, 3'd0, 1'b0);
    cyc("prehold");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.valid", W'(out_valid), '0);
    chk("async.data",  out_data, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post.rdy0", W'(req0_ready), 16'd1);
    cyc("post");
    chk("post.idlit", W'(out_id), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
